// File: rtl/mpi_tick_sequencer.sv
// ---------------------------------------------------------------------------
// mpi_tick_sequencer
//
// Purpose
//   Drives one Metro-MPI partition top from a single start command. The DUT
//   is first clocked through RESET_TICKS work pulses while its reset is held.
//   Reset is then released and num_ticks run pulses are issued, each one
//   waiting for the partition's valid before the next. The sequence ends
//   with a finalize request held for FIN_CYCLES cycles, followed by done.
//
// Ports
//   clk_i         in   1       clock
//   rstn_i        in   1       asynchronous active-low reset
//   start_i       in   1       begin a sequence (sampled in IDLE/DONE only)
//   num_ticks_i   in   TICK_W  run ticks requested, captured on accepted start
//   abort_i       in   1       jump to finalize from RST/REL/ISSUE/WAIT
//   valid_i       in   1       partition valid: tick exchange complete
//   rank_i        in   32      partition rank
//   dut_rstn_o    out  1       active-low reset to the partition
//   mpi_work_o    out  1       one-cycle work pulse to the partition
//   finalize_o    out  1       finalize request to the partition
//   tick_count_o  out  TICK_W  run pulses issued since last start (saturating)
//   rank_o        out  32      rank captured on first valid after reset release
//   busy_o        out  1       high in every state except IDLE/DONE
//   done_o        out  1       high in DONE
//   err_o         out  1       sticky valid timeout, cleared on accepted start
// ---------------------------------------------------------------------------
module mpi_tick_sequencer #(
    parameter int RESET_TICKS = 5,
    parameter int PULSE_GAP   = 1,
    parameter int TICK_W      = 32,
    parameter int TIMEOUT     = 1024,
    parameter int FIN_CYCLES  = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [TICK_W-1:0] num_ticks_i,
    input  logic              abort_i,
    input  logic              valid_i,
    input  logic [31:0]       rank_i,
    output logic              dut_rstn_o,
    output logic              mpi_work_o,
    output logic              finalize_o,
    output logic [TICK_W-1:0] tick_count_o,
    output logic [31:0]       rank_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // Counter widths. The wait timer has to reach both the minimum gap and
    // the timeout limit, so it is sized for whichever is larger.
    localparam int RST_W    = (RESET_TICKS > 1) ? $clog2(RESET_TICKS) : 1;
    localparam int GAP_W    = (PULSE_GAP > 0) ? $clog2(PULSE_GAP + 1) : 1;
    localparam int WAIT_MAX = (TIMEOUT > PULSE_GAP) ? TIMEOUT : PULSE_GAP;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int FIN_W    = (FIN_CYCLES > 1) ? $clog2(FIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        REL,
        ISSUE,
        WAIT,
        FIN,
        DONE
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   target;
    logic [RST_W-1:0]    rst_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [FIN_W-1:0]    fin_cnt;
    logic                rank_seen;

    // Single sequencing process. Every output is a register, so each
    // transition sets up the outputs that the next state must present in
    // its first cycle (e.g. the transition into RST already raises
    // mpi_work_o, giving one cycle from start to the first pulse).
    // Rank capture sits ahead of the state case so that an accepted start
    // in the same cycle overrides it and clears the captured rank.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            dut_rstn_o   <= 1'b0;
            mpi_work_o   <= 1'b0;
            finalize_o   <= 1'b0;
            tick_count_o <= '0;
            rank_o       <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            target       <= '0;
            rst_cnt      <= '0;
            gap_cnt      <= '0;
            wait_cnt     <= '0;
            fin_cnt      <= '0;
            rank_seen    <= 1'b0;
        end else begin
            // Only a valid from a partition that is out of reset carries a
            // meaningful rank.
            if (valid_i && dut_rstn_o && !rank_seen) begin
                rank_o    <= rank_i;
                rank_seen <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        target       <= num_ticks_i;
                        tick_count_o <= '0;
                        err_o        <= 1'b0;
                        rank_o       <= '0;
                        rank_seen    <= 1'b0;
                        dut_rstn_o   <= 1'b0;
                        mpi_work_o   <= 1'b1;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        rst_cnt      <= '0;
                        gap_cnt      <= '0;
                        state        <= RST;
                    end
                end

                // Reset pulse train: gap_cnt==0 is the pulse cycle, the
                // following PULSE_GAP cycles are idle. Aborting here releases
                // reset so the partition sees finalize out of reset.
                RST: begin
                    if (abort_i) begin
                        dut_rstn_o <= 1'b1;
                        mpi_work_o <= 1'b0;
                        finalize_o <= 1'b1;
                        fin_cnt    <= '0;
                        state      <= FIN;
                    end else if (gap_cnt == GAP_W'(PULSE_GAP)) begin
                        if (rst_cnt == RST_W'(RESET_TICKS - 1)) begin
                            dut_rstn_o <= 1'b1;
                            mpi_work_o <= 1'b0;
                            state      <= REL;
                        end else begin
                            rst_cnt    <= rst_cnt + 1'b1;
                            gap_cnt    <= '0;
                            mpi_work_o <= 1'b1;
                        end
                    end else begin
                        gap_cnt    <= gap_cnt + 1'b1;
                        mpi_work_o <= 1'b0;
                    end
                end

                // One settle cycle with reset released.
                REL: begin
                    if (!abort_i && target != '0) begin
                        mpi_work_o <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        finalize_o <= 1'b1;
                        fin_cnt    <= '0;
                        state      <= FIN;
                    end
                end

                // The pulse goes out during this cycle regardless of abort,
                // so it is always counted.
                ISSUE: begin
                    mpi_work_o <= 1'b0;
                    wait_cnt   <= '0;
                    if (tick_count_o != '1) begin
                        tick_count_o <= tick_count_o + 1'b1;
                    end
                    if (abort_i) begin
                        finalize_o <= 1'b1;
                        fin_cnt    <= '0;
                        state      <= FIN;
                    end else begin
                        state <= WAIT;
                    end
                end

                // valid_i is ignored for the first PULSE_GAP cycles. After
                // that a valid outranks a timeout landing on the same cycle,
                // and abort outranks both.
                WAIT: begin
                    if (abort_i) begin
                        finalize_o <= 1'b1;
                        fin_cnt    <= '0;
                        state      <= FIN;
                    end else if (valid_i && wait_cnt >= WAIT_W'(PULSE_GAP)) begin
                        if (tick_count_o == target) begin
                            finalize_o <= 1'b1;
                            fin_cnt    <= '0;
                            state      <= FIN;
                        end else begin
                            mpi_work_o <= 1'b1;
                            state      <= ISSUE;
                        end
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        err_o      <= 1'b1;
                        finalize_o <= 1'b1;
                        fin_cnt    <= '0;
                        state      <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                FIN: begin
                    mpi_work_o <= 1'b0;
                    if (fin_cnt == FIN_W'(FIN_CYCLES - 1)) begin
                        finalize_o <= 1'b0;
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                        state      <= DONE;
                    end else begin
                        fin_cnt <= fin_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpi_tick_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mpi_tick_sequencer
//
// Purpose
//   Self-checking bench for mpi_tick_sequencer. A responder process plays the
//   partition (valid after a configurable delay, rank values, abort timing).
//   The stimulus task computes each run's expected outcome from the sequence
//   rules and queues it. A monitor observes the pulse train and pops the
//   expectation when done_o rises.
// ---------------------------------------------------------------------------
module tb_mpi_tick_sequencer;

    localparam int RESET_TICKS = 5;
    localparam int PULSE_GAP   = 1;
    localparam int TICK_W      = 8;
    localparam int TIMEOUT     = 8;
    localparam int FIN_CYCLES  = 2;
    localparam int RUN_BUDGET  = 20000;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              start_i;
    logic [TICK_W-1:0] num_ticks_i;
    logic              abort_i;
    logic              valid_i;
    logic [31:0]       rank_i;
    logic              dut_rstn_o;
    logic              mpi_work_o;
    logic              finalize_o;
    logic [TICK_W-1:0] tick_count_o;
    logic [31:0]       rank_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    mpi_tick_sequencer #(
        .RESET_TICKS (RESET_TICKS),
        .PULSE_GAP   (PULSE_GAP),
        .TICK_W      (TICK_W),
        .TIMEOUT     (TIMEOUT),
        .FIN_CYCLES  (FIN_CYCLES)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .start_i      (start_i),
        .num_ticks_i  (num_ticks_i),
        .abort_i      (abort_i),
        .valid_i      (valid_i),
        .rank_i       (rank_i),
        .dut_rstn_o   (dut_rstn_o),
        .mpi_work_o   (mpi_work_o),
        .finalize_o   (finalize_o),
        .tick_count_o (tick_count_o),
        .rank_o       (rank_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected outcome of one complete run.
    typedef struct {
        int tick;
        int err;
        longint rank;
        int rst_pulses;
        int run_pulses;
        int fin_cycles;
        int fin_gap;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Partition behaviour for the current run.
    int          cfg_delay [256];
    int          cfg_stall     = -1;
    int          cfg_abort     = -1;
    int          cfg_abort_rst = 0;
    logic [31:0] cfg_rank      = '0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_dut_rstn"}, dut_rstn_o, 0);
        checkOutput({tag, "_mpi_work"}, mpi_work_o, 0);
        checkOutput({tag, "_finalize"}, finalize_o, 0);
        checkOutput({tag, "_tick_count"}, tick_count_o, 0);
        checkOutput({tag, "_rank"}, rank_o, 0);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_err"}, err_o, 0);
    endtask

    // Partition model: valid_i one cycle, cfg_delay cycles after each run
    // pulse; rank_i steps after every valid so only the first one matches
    // cfg_rank. Reset pulses sometimes get a stray valid with a junk rank.
    initial begin : responder
        int pulses;
        int given;
        int due;
        valid_i = 1'b0;
        abort_i = 1'b0;
        rank_i  = '0;
        pulses  = 0;
        given   = 0;
        due     = -1;
        forever begin
            @(negedge clk_i);
            valid_i = 1'b0;
            abort_i = 1'b0;
            rank_i  = cfg_rank + 32'(given);
            if (!busy_o) begin
                pulses = 0;
                given  = 0;
                due    = -1;
            end else begin
                if (due > 0) begin
                    due--;
                    if (due == 0) begin
                        valid_i = 1'b1;
                        rank_i  = cfg_rank + 32'(given);
                        given++;
                        due = -1;
                        if (pulses == cfg_abort) abort_i = 1'b1;
                    end
                end
                if (mpi_work_o && !dut_rstn_o) begin
                    if (cfg_abort_rst != 0) abort_i = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin
                        valid_i = 1'b1;
                        rank_i  = 32'hDEAD_BEEF;
                    end
                end
                if (mpi_work_o && dut_rstn_o) begin
                    pulses++;
                    if (pulses != cfg_stall) due = cfg_delay[pulses-1];
                end
            end
        end
    end

    // Monitor: counts pulses and finalize cycles of each run and compares
    // against the queued expectation when done_o rises.
    initial begin : monitor
        int   cyc, rst_p, run_p, fin_c, fin_gap, last_rst, last_run;
        logic prev_busy, prev_fin, prev_done;
        exp_t e;
        cyc = 0; rst_p = 0; run_p = 0; fin_c = 0; fin_gap = -1;
        last_rst = 0; last_run = 0;
        prev_busy = 1'b0; prev_fin = 1'b0; prev_done = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rstn_i) begin
                rst_p = 0; run_p = 0; fin_c = 0; fin_gap = -1;
                prev_busy = 1'b0; prev_fin = 1'b0; prev_done = 1'b0;
            end else begin
                if (busy_o && !prev_busy) begin
                    rst_p = 0; run_p = 0; fin_c = 0; fin_gap = -1;
                    checkOutput("start_to_first_work", mpi_work_o, 1);
                end
                if (mpi_work_o && !dut_rstn_o) begin
                    if (rst_p > 0) checkOutput("reset_pulse_spacing", cyc - last_rst, PULSE_GAP + 1);
                    rst_p++;
                    last_rst = cyc;
                end
                if (mpi_work_o && dut_rstn_o) begin
                    if (run_p > 0) checkOutput("run_spacing_min", (cyc - last_run) >= PULSE_GAP + 1, 1);
                    else checkOutput("resets_before_run", rst_p, RESET_TICKS);
                    run_p++;
                    last_run = cyc;
                end
                if (finalize_o) begin
                    if (!prev_fin) fin_gap = (run_p > 0) ? cyc - last_run : -1;
                    fin_c++;
                    checkOutput("fin_dut_rstn", dut_rstn_o, 1);
                    checkOutput("fin_no_work", mpi_work_o, 0);
                end
                if (done_o && !prev_done) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_done: actual=done required=no_done");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("done_tick_count", tick_count_o, e.tick);
                        checkOutput("done_err", err_o, e.err);
                        checkOutput("done_rank", rank_o, e.rank);
                        checkOutput("done_reset_pulses", rst_p, e.rst_pulses);
                        checkOutput("done_run_pulses", run_p, e.run_pulses);
                        checkOutput("done_fin_cycles", fin_c, e.fin_cycles);
                        checkOutput("done_fin_gap", fin_gap, e.fin_gap);
                        checkOutput("done_busy", busy_o, 0);
                    end
                end
                prev_busy = busy_o;
                prev_fin  = finalize_o;
                prev_done = done_o;
            end
        end
    end

    // One run. dly=0 picks random valid delays in [2, TIMEOUT]; stall=k
    // withholds valid after run pulse k; abort_at=k aborts together with
    // the valid of pulse k; abort_rst aborts on the first reset pulse.
    // inject=1 pulses start mid-run, inject=2 pulls rstn_i low at tick 4.
    task automatic applyStimulus(input int n, input int dly, input int stall, input int abort_at,
                                 input int abort_rst, input logic [31:0] rank_base, input int inject);
        exp_t e;
        int   waited;
        for (int i = 0; i < 256; i++) begin
            cfg_delay[i] = (dly > 0) ? dly : int'($urandom_range(2, TIMEOUT));
        end
        cfg_stall     = (stall > 0) ? stall : -1;
        cfg_abort     = (abort_at > 0) ? abort_at : -1;
        cfg_abort_rst = abort_rst;
        cfg_rank      = rank_base;

        e.fin_cycles = FIN_CYCLES;
        e.rst_pulses = (abort_rst != 0) ? 1 : RESET_TICKS;
        if (abort_rst != 0) begin
            e.tick = 0; e.err = 0; e.rank = 0; e.run_pulses = 0; e.fin_gap = -1;
        end else if (stall > 0) begin
            e.tick = stall; e.err = 1; e.run_pulses = stall;
            e.rank = (stall > 1) ? longint'(rank_base) : 0;
            e.fin_gap = TIMEOUT + 1;
        end else if (abort_at > 0) begin
            e.tick = abort_at; e.err = 0; e.run_pulses = abort_at;
            e.rank = longint'(rank_base);
            e.fin_gap = cfg_delay[abort_at-1] + 1;
        end else begin
            e.tick = n; e.err = 0; e.run_pulses = n;
            e.rank = (n > 0) ? longint'(rank_base) : 0;
            e.fin_gap = (n > 0) ? cfg_delay[n-1] + 1 : -1;
        end
        if (inject != 2) exp_q.push_back(e);

        @(negedge clk_i);
        start_i     = 1'b1;
        num_ticks_i = TICK_W'(n);
        @(negedge clk_i);
        start_i     = 1'b0;
        num_ticks_i = TICK_W'($urandom);

        if (inject == 1) begin
            waited = 0;
            while (tick_count_o < 2 && waited < RUN_BUDGET) begin
                @(negedge clk_i);
                waited++;
            end
            checkOutput("mid_start_reached_tick2", tick_count_o >= 2, 1);
            start_i     = 1'b1;
            num_ticks_i = TICK_W'(99);
            @(negedge clk_i);
            start_i = 1'b0;
        end

        if (inject == 2) begin
            waited = 0;
            while (tick_count_o != TICK_W'(4) && waited < RUN_BUDGET) begin
                @(negedge clk_i);
                waited++;
            end
            checkOutput("reset_reached_tick4", tick_count_o, 4);
            #3 rstn_i = 1'b0;
            #1 checkResetState("midrun_reset");
            @(negedge clk_i);
            @(negedge clk_i);
            rstn_i = 1'b1;
            @(negedge clk_i);
            return;
        end

        waited = 0;
        while (!done_o && waited < RUN_BUDGET) begin
            @(negedge clk_i);
            waited++;
        end
        if (!done_o) begin
            total++;
            bad++;
            $display("[TB] FAIL run_timeout: actual=no_done required=done within %0d cycles", RUN_BUDGET);
        end
        @(negedge clk_i);
    endtask

    initial begin : stimulus
        start_i     = 1'b0;
        num_ticks_i = '0;
        rstn_i      = 1'b1;
        #3 rstn_i = 1'b0;
        #1 checkResetState("por");
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        checkResetState("idle");

        $display("[TB] directed runs");
        applyStimulus(20, 2, 0, 0, 0, 32'h0000_0011, 0);
        applyStimulus(0, 2, 0, 0, 0, 32'h0000_0022, 0);
        applyStimulus(10, 0, 3, 0, 0, 32'h0000_0033, 0);
        applyStimulus(12, 0, 0, 7, 0, 32'h0000_0044, 0);
        applyStimulus(10, 0, 0, 0, 0, 32'h0000_0055, 2);
        applyStimulus(2, 0, 0, 0, 0, 32'h0000_0066, 0);
        applyStimulus(8, 0, 0, 0, 0, 32'd3, 1);
        applyStimulus(6, 0, 0, 0, 1, 32'h0000_0077, 0);
        applyStimulus(5, TIMEOUT, 0, 0, 0, 32'h0000_0088, 0);
        applyStimulus(1, 0, 1, 0, 0, 32'h0000_0099, 0);
        applyStimulus(255, 2, 0, 0, 0, 32'h0000_00AA, 0);

        $display("[TB] random runs");
        for (int r = 0; r < 10; r++) begin
            int n;
            int mode;
            n    = int'($urandom_range(2, 40));
            mode = int'($urandom_range(0, 2));
            case (mode)
                1:       applyStimulus(n, 0, int'($urandom_range(1, n)), 0, 0, $urandom, 0);
                2:       applyStimulus(n, 0, 0, int'($urandom_range(2, n)), 0, $urandom, 0);
                default: applyStimulus(n, 0, 0, 0, 0, $urandom, 0);
            endcase
        end

        repeat (4) @(negedge clk_i);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
